// File: rtl/dec_bcd_key_encoder.sv
// Decimal-to-BCD key encoder for a 10-line key bank.
// The raw lines are synchronised and debounced, and the highest pressed index is encoded.
// Each accepted press is delivered once as a registered BCD code on a valid/ready handshake.
module dec_bcd_key_encoder #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] KEY,
    input  logic       ready,
    output logic [3:0] BCD,
    output logic       valid,
    output logic       multi,
    output logic       overrun
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    state_t                       state;
    logic [CW-1:0]                cnt;
    logic [9:0]                   snap;
    logic [SYNC_STAGES-1:0][9:0]  sync_q;
    logic [9:0]                   key_s;
    logic [3:0]                   code;
    logic                         multi_code;

    assign key_s = sync_q[SYNC_STAGES-1];

    // Highest set index wins, as in a 74147.
    // A set bit in 9 can never produce codes 10..15.
    function automatic logic [3:0] hi_index(input logic [9:0] s);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 10; i++)
            if (s[i]) r = 4'(i);
        return r;
    endfunction

    function automatic logic [3:0] ones(input logic [9:0] s);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++)
            n = n + {3'b000, s[i]};
        return n;
    endfunction

    assign code       = hi_index(snap);
    assign multi_code = (ones(snap) > 4'd1);

    // Synchroniser chain; stage 0 samples the raw asynchronous lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], KEY};
    end

    // Debounce FSM and registered outputs. An accept in the same cycle as a consumption wins over the clear of valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            snap    <= '0;
            BCD     <= 4'd0;
            valid   <= 1'b0;
            multi   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (valid && ready) valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_s != 10'd0) begin
                        snap  <= key_s;
                        cnt   <= '0;
                        state <= DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (key_s != snap) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                        if (!valid || ready) begin
                            BCD   <= code;
                            multi <= multi_code;
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (key_s == 10'd0) begin
                        cnt   <= '0;
                        state <= DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (key_s != 10'd0)       state <= HELD;
                    else if (cnt == CNT_LAST) state <= IDLE;
                    else                      cnt   <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_bcd_key_encoder.sv
// Directed bench for dec_bcd_key_encoder with SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
module tb_dec_bcd_key_encoder;

    logic       clk;
    logic       rst_n;
    logic [9:0] KEY;
    logic       ready;
    logic [3:0] BCD;
    logic       valid;
    logic       multi;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    dec_bcd_key_encoder #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .KEY(KEY), .ready(ready),
        .BCD(BCD), .valid(valid), .multi(multi), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step n cycles and record every cycle with valid high. With ready=1, each such cycle is one delivered event.
    task automatic count_events(input int n, output int ev, output logic [3:0] b, output logic m);
        ev = 0; b = 4'hF; m = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            if (valid) begin
                ev++; b = BCD; m = multi;
            end
        end
    endtask

    // Release all keys and wait long enough for the release debounce to complete.
    task automatic go_idle();
        KEY = 10'd0;
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; KEY = 10'd0; ready = 1'b1;
        #12;
        checks++;
        if ({BCD, valid, multi, overrun} !== 7'd0) begin
            errors++; $display("FAIL reset_outputs: got %b want 0000000", {BCD, valid, multi, overrun});
        end
        #5 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_single_press();
        int ev; logic [3:0] b; logic m;
        logic early;
        early = 1'b0;
        KEY = 10'b0010000000;
        for (int i = 0; i < 6; i++) begin
            step();
            if (valid) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++; $display("FAIL latency_early: valid rose before edge 7");
        end
        step();
        checks++;
        if ({valid, BCD, multi} !== {1'b1, 4'd7, 1'b0}) begin
            errors++; $display("FAIL latency_edge7: got valid=%b bcd=%0d multi=%b want 1 7 0", valid, BCD, multi);
        end
        count_events(13, ev, b, m);
        checks++;
        if (ev !== 0) begin
            errors++; $display("FAIL single_pulse: got %0d extra events want 0", ev);
        end
        KEY = 10'd0;
        for (int i = 0; i < 10; i++) step();
        KEY = 10'b0010000000;
        count_events(20, ev, b, m);
        checks++;
        if (ev !== 1 || b !== 4'd7) begin
            errors++; $display("FAIL repress: got events=%0d bcd=%0d want 1 7", ev, b);
        end
        go_idle();
    endtask

    task automatic test_multi();
        int ev; logic [3:0] b; logic m;
        KEY = 10'b1000001000;
        count_events(20, ev, b, m);
        checks++;
        if (ev !== 1 || b !== 4'd9 || m !== 1'b1) begin
            errors++; $display("FAIL multi_key: got events=%0d bcd=%0d multi=%b want 1 9 1", ev, b, m);
        end
        go_idle();
    endtask

    task automatic test_bounce();
        int ev; logic [3:0] b; logic m;
        int tot;
        tot = 0;
        KEY = 10'd0;
        for (int p = 0; p < 6; p++) begin
            KEY[5] = ~KEY[5];
            count_events(2, ev, b, m);
            tot += ev;
        end
        checks++;
        if (tot !== 0) begin
            errors++; $display("FAIL bounce_quiet: got %0d events want 0", tot);
        end
        KEY = 10'b0000100000;
        count_events(20, ev, b, m);
        checks++;
        if (ev !== 1 || b !== 4'd5) begin
            errors++; $display("FAIL bounce_settle: got events=%0d bcd=%0d want 1 5", ev, b);
        end
        go_idle();
    endtask

    task automatic test_overrun();
        int pulses;
        ready = 1'b0;
        KEY = 10'b0000000100;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if ({valid, BCD} !== {1'b1, 4'd2}) begin
            errors++; $display("FAIL hold_first: got valid=%b bcd=%0d want 1 2", valid, BCD);
        end
        KEY = 10'd0;
        for (int i = 0; i < 10; i++) step();
        KEY = 10'b0000010000;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (overrun) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL overrun_pulse: got %0d pulse cycles want 1", pulses);
        end
        checks++;
        if ({valid, BCD} !== {1'b1, 4'd2}) begin
            errors++; $display("FAIL overrun_keep: got valid=%b bcd=%0d want 1 2", valid, BCD);
        end
        ready = 1'b1;
        step();
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL consume_drop: got valid=%b want 0", valid);
        end
        go_idle();
    endtask

    task automatic test_key0();
        int ev; logic [3:0] b; logic m;
        KEY = 10'b0000000001;
        count_events(20, ev, b, m);
        checks++;
        if (ev !== 1 || b !== 4'd0 || m !== 1'b0) begin
            errors++; $display("FAIL key0: got events=%0d bcd=%0d multi=%b want 1 0 0", ev, b, m);
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        logic early;
        // Leave an unconsumed event so that the reset has visible state to clear.
        ready = 1'b0;
        KEY = 10'b0000001000;
        for (int i = 0; i < 10; i++) step();
        KEY = 10'd0;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if ({valid, BCD} !== {1'b1, 4'd3}) begin
            errors++; $display("FAIL pre_reset_hold: got valid=%b bcd=%0d want 1 3", valid, BCD);
        end
        KEY = 10'b0100000000;
        for (int i = 0; i < 4; i++) step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({BCD, valid, multi, overrun} !== 7'd0) begin
            errors++; $display("FAIL async_reset: got %b want 0000000", {BCD, valid, multi, overrun});
        end
        ready = 1'b1;
        #2 rst_n = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (valid) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++; $display("FAIL post_reset_early: valid rose before edge 7");
        end
        step();
        checks++;
        if ({valid, BCD, multi} !== {1'b1, 4'd8, 1'b0}) begin
            errors++; $display("FAIL post_reset_event: got valid=%b bcd=%0d multi=%b want 1 8 0", valid, BCD, multi);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_multi();
        test_bounce();
        test_overrun();
        test_key0();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
